// File: rtl/tt_bin_clock_ctrl.sv
// Binary clock control: button conditioning, set-mode FSM and 1 s tick.
// Define BIN_CLOCK_AUTO_REPEAT_EN to auto-repeat held up/down keys.
module tt_bin_clock_ctrl #(
   parameter int TICK_DIV        = 10_000_000,
   parameter int DEBOUNCE_CYCLES = 200_000,
   parameter int REPEAT_DELAY    = 5_000_000,
   parameter int REPEAT_PERIOD   = 2_000_000
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       mode_i,
   input  logic       up_i,
   input  logic       down_i,
   output logic [1:0] hour_id_o,
   output logic [1:0] minute_id_o,
   output logic [1:0] seconds_id_o,
   output logic       tick_o,
   output logic [1:0] set_field_o
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_HOUR = 2'b01,
      ST_MIN  = 2'b10,
      ST_SEC  = 2'b11
   } state_e;

   // bit 0 mode, bit 1 up, bit 2 down
   logic [2:0]    s1_q, s1_d, s2_q, s2_d;
   logic [2:0]    deb_q, deb_d, prev_q, prev_d;
   logic [DW-1:0] dcnt_q [3];
   logic [DW-1:0] dcnt_d [3];
   logic [2:0]    rise;

   state_e        state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          tick_q, tick_d;
   logic [1:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;

   logic mode_rise, up_lvl, dn_lvl, in_set;
   logic up_go, dn_go, rep_inc, rep_dec;

   assign rise      = deb_q & ~prev_q;
   assign mode_rise = rise[0];
   assign up_lvl    = deb_q[1];
   assign dn_lvl    = deb_q[2];
   assign in_set    = (state_q != ST_RUN);

   // A fresh press counts only when the opposite key is not held.
   assign up_go = in_set && !mode_rise && rise[1] && !dn_lvl;
   assign dn_go = in_set && !mode_rise && rise[2] && !up_lvl;

   // Synchronize and debounce: a level is taken after a full run of agreement.
   always_comb begin
      s1_d   = {down_i, up_i, mode_i};
      s2_d   = s1_q;
      prev_d = deb_q;
      deb_d  = deb_q;
      for (int i = 0; i < 3; i++) begin
         dcnt_d[i] = '0;
         if (s2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
               deb_d[i] = s2_q[i];
            else
               dcnt_d[i] = dcnt_q[i] + DW'(1);
         end
      end
   end

`ifdef BIN_CLOCK_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

   logic          rep_act_q, rep_act_d;
   logic          rep_up_q, rep_up_d;
   logic          rep_first_q, rep_first_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_lim;
   logic          rep_stop, rep_hit;

   // Repeat is armed by a real pulse and dies on release, other key or mode.
   always_comb begin
      rep_lim  = rep_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
      rep_stop = !in_set || mode_rise ||
                 (rep_up_q ? (!up_lvl || dn_lvl) : (!dn_lvl || up_lvl));
      rep_hit  = rep_act_q && !rep_stop && (rep_cnt_q == rep_lim);
      rep_act_d   = rep_act_q;
      rep_up_d    = rep_up_q;
      rep_first_d = rep_first_q;
      rep_cnt_d   = rep_cnt_q;
      if (up_go || dn_go) begin
         rep_act_d   = 1'b1;
         rep_up_d    = up_go;
         rep_first_d = 1'b1;
         rep_cnt_d   = '0;
      end else if (rep_stop) begin
         rep_act_d   = 1'b0;
         rep_first_d = 1'b0;
         rep_cnt_d   = '0;
      end else if (rep_act_q) begin
         if (rep_hit) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
         end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
         end
      end
   end

   assign rep_inc = rep_hit && rep_up_q;
   assign rep_dec = rep_hit && !rep_up_q;

   // Repeat state registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rep_act_q   <= 1'b0;
         rep_up_q    <= 1'b0;
         rep_first_q <= 1'b0;
         rep_cnt_q   <= '0;
      end else begin
         rep_act_q   <= rep_act_d;
         rep_up_q    <= rep_up_d;
         rep_first_q <= rep_first_d;
         rep_cnt_q   <= rep_cnt_d;
      end
   end
`else
   assign rep_inc = 1'b0;
   assign rep_dec = 1'b0;
`endif

   // Mode FSM, prescaler and registered adjust pulses.
   always_comb begin
      logic [1:0] id;
      state_d = state_q;
      if (mode_rise) begin
         unique case (state_q)
            ST_RUN:  state_d = ST_HOUR;
            ST_HOUR: state_d = ST_MIN;
            ST_MIN:  state_d = ST_SEC;
            ST_SEC:  state_d = ST_RUN;
         endcase
      end
      pcnt_d = '0;
      tick_d = 1'b0;
      if (!in_set) begin
         pcnt_d = (pcnt_q == PW'(TICK_DIV - 1)) ? '0 : pcnt_q + PW'(1);
         tick_d = (pcnt_d == PW'(TICK_DIV - 1));
      end
      id     = {up_go || rep_inc, dn_go || rep_dec};
      hour_d = (state_q == ST_HOUR) ? id : 2'b00;
      min_d  = (state_q == ST_MIN)  ? id : 2'b00;
      sec_d  = (state_q == ST_SEC)  ? id : 2'b00;
   end

   // All control state, cleared at once by reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_q    <= '0;
         s2_q    <= '0;
         deb_q   <= '0;
         prev_q  <= '0;
         for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
         state_q <= ST_RUN;
         pcnt_q  <= '0;
         tick_q  <= 1'b0;
         hour_q  <= 2'b00;
         min_q   <= 2'b00;
         sec_q   <= 2'b00;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         deb_q   <= deb_d;
         prev_q  <= prev_d;
         for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         tick_q  <= tick_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
      end
   end

   assign hour_id_o    = hour_q;
   assign minute_id_o  = min_q;
   assign seconds_id_o = sec_q;
   assign tick_o       = tick_q;
   assign set_field_o  = state_q;

endmodule

// File: doc/tt_bin_clock_ctrl.md
TT_BIN_CLOCK_CTRL -- requirements
Module: tt_bin_clock_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clk_i cycles per one-second tick (10 MHz clock).
REQ-002 Parameter DEBOUNCE_CYCLES, default 200_000, consecutive stable cycles required to accept a button level (20 ms).
REQ-003 Parameter REPEAT_DELAY, default 5_000_000, hold cycles after the first pulse before auto-repeat begins.
REQ-004 Parameter REPEAT_PERIOD, default 2_000_000, cycles between auto-repeat pulses.
REQ-005 clk_i  input  1  single clock; all state on its rising edge.
REQ-006 rstn_i  input  1  reset, asynchronous, active-low.
REQ-007 mode_i  input  1  raw "mode" button, asynchronous, active-high.
REQ-008 up_i  input  1  raw "up" button, asynchronous, active-high.
REQ-009 down_i  input  1  raw "down" button, asynchronous, active-high.
REQ-010 hour_id_o  output  2  hour adjust; bit1 = increment pulse, bit0 = decrement pulse.
REQ-011 minute_id_o  output  2  minute adjust; same encoding.
REQ-012 seconds_id_o  output  2  seconds adjust; same encoding.
REQ-013 tick_o  output  1  one-cycle one-second enable for the clock datapath.
REQ-014 set_field_o  output  2  00 RUN, 01 hour, 10 minute, 11 seconds.

Function
REQ-015 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer whose output takes the synchronized level once it has held for DEBOUNCE_CYCLES consecutive cycles; any mismatch restarts the count.
REQ-016 "Press" = debounced 0->1 transition; an id pulse or state change SHALL register one cycle after the debounced level rises (raw-to-output latency 2 + DEBOUNCE_CYCLES + 1 cycles).
REQ-017 FSM states RUN, SET_HOUR, SET_MIN, SET_SEC; mode press advances RUN->SET_HOUR->SET_MIN->SET_SEC->RUN; set_field_o reflects state.
REQ-018 RUN: prescaler counts 0..TICK_DIV-1, tick_o high exactly in the cycle the count is TICK_DIV-1, then wraps to 0; up/down ignored; all id outputs 0.
REQ-019 SET_*: tick_o 0 and prescaler held at 0; on RUN re-entry first tick is TICK_DIV cycles later.
REQ-020 SET_*: up press SHALL drive bit1 of the selected field's id output high for exactly one cycle; down press drives bit0; unselected fields stay 00.
REQ-021 Up and down debounced high together: no pulse, including presses in the same cycle; pulsing resumes only on a fresh press after both are released.
REQ-022 Any id output SHALL never be 11; at most one id output non-zero per cycle.
REQ-023 Mode press coinciding with up/down press: state change wins, no id pulse; a key held across a field change produces nothing until re-pressed.

Reset
REQ-024 rstn_i low SHALL immediately force: state RUN, set_field_o 00, tick_o 0, all id outputs 00, prescaler/debounce/repeat counters 0, synchronizer and debounced levels 0.
REQ-025 Buttons held while rstn_i deasserts SHALL be treated as fresh presses after debounce; reset mid-debounce discards the partial count.

Configuration
REQ-026 Macro BIN_CLOCK_AUTO_REPEAT_EN defined: in SET_*, up or down held alone for REPEAT_DELAY cycles after its initial pulse emits another pulse, then one every REPEAT_PERIOD cycles; release, the other key, mode press, or reset stops and clears repeat.
REQ-027 Macro undefined: no repeat logic or counter is built; exactly one pulse per press; REPEAT_DELAY/REPEAT_PERIOD are ignored.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 Reset released, no buttons -> tick_o pulses at cycles 10, 20, 30 after reset; set_field_o=00; all id outputs 00.
REQ-029 mode_i high 3 cycles then low -> no state change (bounce rejected); held 8 cycles -> set_field_o=01 at cycle 7 after assertion; three further presses -> 10, 11, 00.
REQ-030 SET_MIN, up_i held 10 cycles -> minute_id_o=10 for exactly one cycle, hour/seconds stay 00, tick_o stays 0.
REQ-031 SET_HOUR, up_i and down_i rise same cycle -> no pulse; release both, press down_i -> hour_id_o=01 for one cycle.
REQ-032 BIN_CLOCK_AUTO_REPEAT_EN defined, SET_SEC, up_i held 60 cycles -> seconds_id_o=10 at press, +20, then every 5 cycles until release; undefined -> single pulse.
REQ-033 rstn_i low mid-repeat in SET_MIN -> outputs 00 immediately, set_field_o=00, first tick 10 cycles after release.
